// File: rtl/quad_decoder_cnt32.sv
// rtl/quad_decoder_cnt32.sv - quadrature A/B decoder with glitch filter and 32-bit up/down position counter
// Phases are synchronized, filtered, then decoded by an INIT/TRACK FSM that steps the counter.
module quad_decoder_cnt32 #(
  parameter int unsigned FILTER = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a,
  input  logic        b,
  input  logic        en,
  input  logic        Load,
  input  logic [31:0] PData,
  output logic [31:0] cnt,
  output logic        dir,
  output logic        step,
  output logic        Rc,
  output logic        err,
  output logic [7:0]  err_cnt
);

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  logic        a_s1_q, a_s_q, b_s1_q, b_s_q;
  logic [1:0]  ab_last_q, ab_last_d;
  logic [3:0]  stab_q, stab_d;
  logic [1:0]  ab_f_q, ab_f_d;
  logic        upd_q, upd_d;
  logic [1:0]  ab_prev_q, ab_prev_d;
  state_t      state_q, state_d;
  logic [31:0] cnt_q, cnt_d;
  logic        dir_q, dir_d;
  logic        step_q, step_d;
  logic        rc_q, rc_d;
  logic        err_q, err_d;
  logic [7:0]  err_cnt_q, err_cnt_d;

  logic [1:0]  ab_s;
  logic [4:0]  run_len;
  logic [1:0]  idx_prev, idx_new, delta;
  logic        is_fwd, is_rev, is_ill, counted;

  always_comb begin
    ab_s      = {a_s_q, b_s_q};
    ab_last_d = ab_s;

    // run_len counts the cycle in which the pair changed as its first stable cycle
    if (ab_s != ab_last_q) begin
      stab_d = 4'd0;
    end else if (stab_q == 4'hF) begin
      stab_d = stab_q;
    end else begin
      stab_d = stab_q + 4'd1;
    end
    run_len = {1'b0, stab_d} + 5'd1;
    upd_d   = (run_len == 5'(FILTER));
    ab_f_d  = upd_d ? ab_s : ab_f_q;

    // Gray code to position index: 00,01,11,10 -> 0,1,2,3
    idx_prev = {ab_prev_q[1], ^ab_prev_q};
    idx_new  = {ab_f_q[1], ^ab_f_q};
    delta    = idx_new - idx_prev;

    is_fwd  = upd_q && (state_q == ST_TRACK) && (delta == 2'd1);
    is_rev  = upd_q && (state_q == ST_TRACK) && (delta == 2'd3);
    is_ill  = upd_q && (state_q == ST_TRACK) && (delta == 2'd2);
    counted = (is_fwd || is_rev) && en && !Load;

    state_d   = state_q;
    ab_prev_d = ab_prev_q;
    if (upd_q) begin
      ab_prev_d = ab_f_q;
      state_d   = ST_TRACK;
    end

    dir_d = dir_q;
    if (is_fwd) begin
      dir_d = 1'b1;
    end else if (is_rev) begin
      dir_d = 1'b0;
    end

    cnt_d = cnt_q;
    if (Load) begin
      cnt_d = PData;
    end else if (counted) begin
      cnt_d = cnt_q + (is_fwd ? 32'd1 : 32'hFFFF_FFFF);
    end

    step_d = counted;
    rc_d   = counted && (is_fwd ? (&cnt_q) : ~(|cnt_q));

    err_d     = is_ill;
    err_cnt_d = err_cnt_q;
    if (is_ill && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_s1_q    <= 1'b0;
      a_s_q     <= 1'b0;
      b_s1_q    <= 1'b0;
      b_s_q     <= 1'b0;
      ab_last_q <= 2'b00;
      stab_q    <= 4'd0;
      ab_f_q    <= 2'b00;
      upd_q     <= 1'b0;
      ab_prev_q <= 2'b00;
      state_q   <= ST_INIT;
      cnt_q     <= 32'd0;
      dir_q     <= 1'b1;
      step_q    <= 1'b0;
      rc_q      <= 1'b0;
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      a_s1_q    <= a;
      a_s_q     <= a_s1_q;
      b_s1_q    <= b;
      b_s_q     <= b_s1_q;
      ab_last_q <= ab_last_d;
      stab_q    <= stab_d;
      ab_f_q    <= ab_f_d;
      upd_q     <= upd_d;
      ab_prev_q <= ab_prev_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_q     <= dir_d;
      step_q    <= step_d;
      rc_q      <= rc_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign cnt     = cnt_q;
  assign dir     = dir_q;
  assign step    = step_q;
  assign Rc      = rc_q;
  assign err     = err_q;
  assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_quad_decoder_cnt32.sv
// tb/tb_quad_decoder_cnt32.sv - scoreboard bench for quad_decoder_cnt32
// Position model works on Gray-sequence indices; a monitor pops expected events on step/err pulses.
module tb_quad_decoder_cnt32;

  localparam int F = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        a = 1'b0;
  logic        b = 1'b0;
  logic        en = 1'b1;
  logic        Load = 1'b0;
  logic [31:0] PData = 32'd0;
  logic [31:0] cnt;
  logic        dir, step, Rc, err;
  logic [7:0]  err_cnt;

  quad_decoder_cnt32 #(.FILTER(F)) dut (
    .clk(clk), .rst(rst), .a(a), .b(b), .en(en), .Load(Load), .PData(PData),
    .cnt(cnt), .dir(dir), .step(step), .Rc(Rc), .err(err), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    bit          is_err;
    int          exp_cyc;
    logic [31:0] cnt;
    bit          dir;
    bit          rc;
    int          ecnt;
  } ev_t;
  ev_t q[$];

  logic [31:0] m_pos = 32'd0;
  bit          m_dir = 1'b1;
  int          m_err = 0;
  int          idx = 0;
  bit          mon_on = 1'b0;
  bit          prev_step = 1'b0;
  bit          prev_err = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (mon_on) begin
      if (step || err) begin
        if (q.size() == 0) begin
          check("unexpected_pulse", 64'({step, err}), 64'd0);
        end else begin
          e = q.pop_front();
          check(e.is_err ? "err_pulse" : "step_pulse", 64'({step, err}),
                e.is_err ? 64'd1 : 64'd2);
          check("event_cycle", 64'(cyc), 64'(e.exp_cyc));
          check("event_cnt", 64'(cnt), 64'(e.cnt));
          check("event_dir", 64'(dir), 64'(e.dir));
          check("event_rc", 64'(Rc), 64'(e.rc));
          if (e.is_err) check("event_err_cnt", 64'(err_cnt), 64'(e.ecnt));
        end
      end
      if (Rc && !step) check("rc_without_step", 64'(Rc), 64'd0);
      if (step && prev_step) check("step_two_cycles", 64'(step), 64'd0);
      if (err && prev_err) check("err_two_cycles", 64'(err), 64'd0);
    end
    prev_step = step;
    prev_err  = err;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] gray_of(input int i);
    case (i % 4)
      0:       return 2'b00;
      1:       return 2'b01;
      2:       return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  task automatic drive_idx(input int nidx);
    {a, b} = gray_of(nidx);
    idx = nidx;
  endtask

  // kind: 0 forward, 1 reverse, 2 illegal (two-bit jump)
  function automatic int next_idx(input int kind);
    return (idx + ((kind == 0) ? 1 : ((kind == 1) ? 3 : 2))) % 4;
  endfunction

  task automatic move(input int kind, input int hold);
    ev_t e;
    int  nidx;
    nidx = next_idx(kind);
    e.is_err  = (kind == 2);
    e.exp_cyc = cyc + F + 3;
    e.rc      = 1'b0;
    e.ecnt    = 0;
    if (kind == 2) begin
      if (m_err < 255) m_err++;
      e.ecnt = m_err;
      e.cnt  = m_pos;
      e.dir  = m_dir;
      q.push_back(e);
    end else begin
      m_dir = (kind == 0);
      if (en) begin
        e.rc  = (kind == 0) ? (m_pos == 32'hFFFF_FFFF) : (m_pos == 32'd0);
        m_pos = (kind == 0) ? m_pos + 32'd1 : m_pos - 32'd1;
        e.cnt = m_pos;
        e.dir = m_dir;
        q.push_back(e);
      end
    end
    drive_idx(nidx);
    repeat (hold) tick();
  endtask

  // Load is timed to be sampled at the very edge the step decodes
  task automatic move_load(input int kind, input logic [31:0] v);
    m_dir = (kind == 0);
    m_pos = v;
    drive_idx(next_idx(kind));
    repeat (F + 2) tick();
    Load  = 1'b1;
    PData = v;
    tick();
    Load = 1'b0;
    repeat (3) tick();
  endtask

  task automatic do_load(input logic [31:0] v);
    Load  = 1'b1;
    PData = v;
    tick();
    Load  = 1'b0;
    m_pos = v;
    check("load_value", 64'(cnt), 64'(v));
  endtask

  task automatic glitch(input int which, input int len);
    if (which == 0) a = ~a; else b = ~b;
    repeat (len) tick();
    {a, b} = gray_of(idx);
    repeat (F + 3) tick();
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && q.size() != 0; i++) tick();
    check("queue_drained", 64'(q.size()), 64'd0);
  endtask

  task automatic check_reset_values();
    check("rst_cnt", 64'(cnt), 64'd0);
    check("rst_dir", 64'(dir), 64'd1);
    check("rst_step", 64'(step), 64'd0);
    check("rst_rc", 64'(Rc), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_err_cnt", 64'(err_cnt), 64'd0);
  endtask

  task automatic check_state(input string name);
    check({name, "_cnt"}, 64'(cnt), 64'(m_pos));
    check({name, "_dir"}, 64'(dir), 64'(m_dir));
    check({name, "_err_cnt"}, 64'(err_cnt), 64'(m_err));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int kind;
    rst = 1'b1;
    a = 1'b1;
    b = 1'b1;
    idx = 2;
    repeat (3) tick();
    check_reset_values();
    rst = 1'b0;
    mon_on = 1'b1;
    repeat (10) tick();
    check("baseline_cnt", 64'(cnt), 64'd0);

    // baseline was 11, so 11->10 must count forward
    move(0, F + 3);
    drain();
    check("baseline_fwd", 64'(cnt), 64'd1);

    do_load(32'd0);
    en = 1'b0;
    move(0, F + 3);
    en = 1'b1;
    drain();
    check_state("en_off");

    repeat (8) move(0, 8);
    drain();
    check("fwd8_cnt", 64'(cnt), 64'd8);
    check("fwd8_dir", 64'(dir), 64'd1);
    repeat (3) move(1, 8);
    drain();
    check("rev3_cnt", 64'(cnt), 64'd5);
    check("rev3_dir", 64'(dir), 64'd0);

    do_load(32'hFFFF_FFFF);
    move(0, F + 3);
    drain();
    check("wrap_up_cnt", 64'(cnt), 64'd0);
    move(1, F + 3);
    drain();
    check("wrap_down_cnt", 64'(cnt), 64'hFFFF_FFFF);

    glitch(0, 3);
    drain();
    check_state("glitch");
    move(2, F + 3);
    drain();
    check("illegal_err_cnt", 64'(err_cnt), 64'd1);
    check("illegal_cnt", 64'(cnt), 64'hFFFF_FFFF);
    repeat (259) move(2, F + 1);
    drain();
    check("err_cnt_sat", 64'(err_cnt), 64'd255);

    move_load(0, 32'h100);
    drain();
    check("collide_cnt", 64'(cnt), 64'h100);
    check("collide_dir", 64'(dir), 64'd1);

    en = 1'b0;
    for (int i = 0; i < 4; i++) move(int'($urandom_range(0, 1)), F + 3);
    en = 1'b1;
    drain();
    check("en0_cnt", 64'(cnt), 64'h100);
    check("en0_dir", 64'(dir), 64'(m_dir));

    for (int i = 0; i < 80; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 5) == 0) glitch(int'($urandom_range(0, 1)), int'($urandom_range(1, F - 1)));
      r = int'($urandom_range(0, 99));
      kind = (r < 45) ? 0 : ((r < 85) ? 1 : 2);
      move(kind, F + 3 + int'($urandom_range(0, 3)));
    end
    en = 1'b1;
    drain();
    check_state("random");

    // reset lands two clocks after the phase edge is sampled
    drive_idx(next_idx(0));
    tick();
    tick();
    rst = 1'b1;
    tick();
    check_reset_values();
    m_pos = 32'd0;
    m_dir = 1'b1;
    m_err = 0;
    rst = 1'b0;
    repeat (15) tick();
    check("post_reset_cnt", 64'(cnt), 64'd0);
    move(0, F + 3);
    drain();
    check("post_reset_fwd", 64'(cnt), 64'd1);
    check_state("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
